// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: size, error and state encodings shared by the load/store unit
package riscv_lsu_pkg;
  typedef enum logic [1:0] {LSU_SIZE_B, LSU_SIZE_H, LSU_SIZE_W, LSU_SIZE_D} lsu_size_e;
  typedef enum logic [1:0] {LSU_ERR_OK, LSU_ERR_MISALIGN, LSU_ERR_TIMEOUT, LSU_ERR_SIZE} lsu_err_e;
  typedef enum logic [1:0] {LSU_ST_IDLE, LSU_ST_ACCESS, LSU_ST_RESP} lsu_st_e;
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte enables, store replication, load extraction and access checks
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   rdata_ext,
  output lsu_err_e          err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  logic [OW-1:0] off;
  logic [XLEN-1:0] lane, m;
  logic sb, misal;
  assign off = addr_lo[OW-1:0];
  assign lane = rdata >> {off, 3'b000};
  always_comb begin
    be = size == LSU_SIZE_B ? NB'(1) << off : size == LSU_SIZE_H ? NB'(3) << off : size == LSU_SIZE_W ? NB'(15) << off : '1;
    wdata_rep = size == LSU_SIZE_B ? {NB{wdata[7:0]}} : size == LSU_SIZE_H ? {(NB/2){wdata[15:0]}}
              : size == LSU_SIZE_W ? {(NB/4){wdata[31:0]}} : wdata;
    m = size == LSU_SIZE_B ? XLEN'(8'hFF) : size == LSU_SIZE_H ? XLEN'(16'hFFFF) : size == LSU_SIZE_W ? XLEN'(32'hFFFF_FFFF) : '1;
    sb = !uns && (size == LSU_SIZE_B ? lane[7] : size == LSU_SIZE_H ? lane[15] : size == LSU_SIZE_W ? lane[31] : 1'b0);
    rdata_ext = (lane & m) | ({XLEN{sb}} & ~m);
    misal = (addr_lo & ((3'd1 << size) - 3'd1)) != 3'd0;
    err = size == LSU_SIZE_D && XLEN == 32 ? LSU_ERR_SIZE : misal ? LSU_ERR_MISALIGN : LSU_ERR_OK;
  end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: multi-cycle load/store unit with bus handshake, MMIO decode and watchdog
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF_FC00,
  parameter int          MMIO_SIZE_LOG2 = 10,
  parameter int          TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              busy,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_sel_io,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [XLEN-1:0] IO_TAG = XLEN'(MMIO_BASE) >> MMIO_SIZE_LOG2;
  lsu_st_e state_q, state_d;
  lsu_err_e err_q, err_d, al_err;
  logic we_q, we_d, uns_q, uns_d, mv_q, mv_d, mwe_q, mwe_d, io_q, io_d;
  logic [1:0] size_q, size_d;
  logic [XLEN-1:0] addr_q, addr_d, wd_q, wd_d, rd_q, rd_d, al_wd, al_rd, req_base;
  logic [NB-1:0] be_q, be_d, al_be;
  logic [CW-1:0] cnt_q, cnt_d;
  logic idle, acc, done, tmo;
  assign idle = state_q == LSU_ST_IDLE;
  assign req_ready = idle && !rst;
  assign acc = req_valid && req_ready;
  assign done = state_q == LSU_ST_ACCESS && mem_ready;
  assign tmo = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  assign req_base = {req_addr[XLEN-1:OW], {OW{1'b0}}};
  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .size      (idle ? req_size : size_q),
    .uns       (idle ? req_unsigned : uns_q),
    .addr_lo   (idle ? req_addr[2:0] : addr_q[2:0]),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wd),
    .rdata_ext (al_rd),
    .err       (al_err)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_ST_IDLE:   state_d = !acc ? LSU_ST_IDLE : al_err == LSU_ERR_OK ? LSU_ST_ACCESS : LSU_ST_RESP;
      LSU_ST_ACCESS: state_d = mem_ready || tmo ? LSU_ST_RESP : LSU_ST_ACCESS;
      default:       state_d = LSU_ST_IDLE;
    endcase
  end
  always_comb begin
    resp_valid = state_q == LSU_ST_RESP;
    busy = !idle;
    resp_rdata = rd_q;
    resp_err = err_q;
    mem_valid = mv_q;
    mem_we = mwe_q;
    mem_be = be_q;
    mem_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    mem_wdata = wd_q;
    mem_sel_io = io_q;
  end
  always_comb begin
    we_d = acc ? req_we : we_q;
    uns_d = acc ? req_unsigned : uns_q;
    size_d = acc ? req_size : size_q;
    addr_d = acc ? req_addr : addr_q;
    be_d = acc ? al_be : be_q;
    wd_d = acc ? al_wd : wd_q;
    mwe_d = acc ? req_we : mwe_q;
    io_d = acc ? (req_base >> MMIO_SIZE_LOG2) == IO_TAG : io_q;
    mv_d = acc ? al_err == LSU_ERR_OK : mv_q && !(mem_ready || tmo);
    err_d = acc ? al_err : state_q == LSU_ST_ACCESS && !mem_ready && tmo ? LSU_ERR_TIMEOUT : err_q;
    rd_d = acc ? '0 : done && !we_q ? al_rd : rd_q;
    cnt_d = state_q == LSU_ST_ACCESS ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wd_q <= '0;
      mwe_q <= 1'b0;
      io_q <= 1'b0;
      mv_q <= 1'b0;
      err_q <= LSU_ERR_OK;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      we_q <= we_d;
      uns_q <= uns_d;
      size_q <= size_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wd_q <= wd_d;
      mwe_q <= mwe_d;
      io_q <= io_d;
      mv_q <= mv_d;
      err_q <= err_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized and directed checks of 32- and 64-bit LSUs against a reference model
module tb_riscv_lsu;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic rv32 = 1'b0, rv64 = 1'b0, req_we = 1'b0, req_uns = 1'b0, mem_ready = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic a_ready, a_rvalid, a_busy, a_mv, a_mwe, a_io;
  logic [31:0] a_rdata, a_maddr, a_mwd;
  logic [1:0] a_err, b_err, o_err;
  logic [3:0] a_be;
  logic b_ready, b_rvalid, b_busy, b_mv, b_mwe, b_io;
  logic [63:0] b_rdata, b_maddr, b_mwd;
  logic [7:0] b_be, o_be;
  logic o_ready, o_rvalid, o_busy, o_mv, o_mwe, o_io;
  logic [63:0] o_rdata, o_maddr, o_mwd;
  bit w_sel = 1'b0;
  int checks = 0, errors = 0;
  int last_lat, last_mvc;
  logic [63:0] last_rdata, last_maddr, last_mwd;
  logic [7:0] last_be;
  logic [1:0] last_err;
  logic last_io, last_mwe;
  riscv_lsu #(.XLEN(32), .TIMEOUT(TO)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(a_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_uns), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy),
    .mem_valid(a_mv), .mem_we(a_mwe), .mem_be(a_be), .mem_addr(a_maddr), .mem_wdata(a_mwd),
    .mem_sel_io(a_io), .mem_ready(mem_ready), .mem_rdata(mem_rdata[31:0])
  );
  riscv_lsu #(.XLEN(64), .TIMEOUT(TO)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(b_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy),
    .mem_valid(b_mv), .mem_we(b_mwe), .mem_be(b_be), .mem_addr(b_maddr), .mem_wdata(b_mwd),
    .mem_sel_io(b_io), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  always_comb begin
    o_ready = w_sel ? b_ready : a_ready;
    o_rvalid = w_sel ? b_rvalid : a_rvalid;
    o_busy = w_sel ? b_busy : a_busy;
    o_mv = w_sel ? b_mv : a_mv;
    o_mwe = w_sel ? b_mwe : a_mwe;
    o_io = w_sel ? b_io : a_io;
    o_err = w_sel ? b_err : a_err;
    o_be = w_sel ? b_be : {4'b0, a_be};
    o_rdata = w_sel ? b_rdata : {32'b0, a_rdata};
    o_maddr = w_sel ? b_maddr : {32'b0, a_maddr};
    o_mwd = w_sel ? b_mwd : {32'b0, a_mwd};
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic txn(input bit w64, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd, input int k);
    int n, nb, off, lat, mvc, elat, emv;
    bit got;
    logic [63:0] wm, bm, ebe, ema, ewd, erd, lane;
    logic [1:0] eerr;
    logic eio;
    nb = w64 ? 8 : 4;
    wm = w64 ? '1 : 64'hFFFF_FFFF;
    n = 1 << sz;
    bm = n == 8 ? '1 : (64'd1 << (8 * n)) - 64'd1;
    off = int'(a[2:0]) & (nb - 1);
    ebe = (((64'd1 << n) - 64'd1) << off) & ((64'd1 << nb) - 64'd1);
    ema = (a & wm) - 64'(off);
    ewd = '0;
    if (n <= nb) for (int i = 0; i < nb / n; i++) ewd |= (wd & bm) << (8 * n * i);
    eio = (ema >> 10) == (64'hFFFF_FC00 >> 10);
    eerr = (sz == 2'd3 && !w64) ? 2'd3 : (a & 64'(n - 1)) != 0 ? 2'd1 : k > TO ? 2'd2 : 2'd0;
    elat = (eerr == 2'd1 || eerr == 2'd3) ? 1 : eerr == 2'd2 ? TO + 1 : k + 1;
    emv = eerr == 2'd0 ? k : eerr == 2'd2 ? TO : 0;
    erd = '0;
    if (eerr == 2'd0 && !we) begin
      lane = (rd >> (8 * off)) & bm;
      if (!uns && lane[8 * n - 1]) lane |= ~bm;
      erd = lane & wm;
    end
    @(negedge clk);
    w_sel = w64;
    req_we = we;
    req_size = sz;
    req_uns = uns;
    req_addr = a & wm;
    req_wdata = wd & wm;
    mem_ready = 1'b0;
    chk("req_ready", o_ready, 1);
    if (w64) rv64 = 1'b1;
    else rv32 = 1'b1;
    @(posedge clk);
    got = 1'b0;
    lat = 0;
    mvc = 0;
    for (int c = 1; c <= 3 * TO + 10 && !got; c++) begin
      @(negedge clk);
      rv32 = 1'b0;
      rv64 = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (o_rvalid) begin
        got = 1'b1;
        lat = c;
        mem_ready = 1'b0;
        chk("mv_in_resp", o_mv, 0);
        chk("busy_resp", o_busy, 1);
        last_rdata = o_rdata;
        last_err = o_err;
      end else begin
        chk("busy", o_busy, 1);
        if (o_mv) begin
          mvc++;
          chk("mem_be", o_be, ebe);
          chk("mem_addr", o_maddr, ema);
          chk("mem_wdata", o_mwd, ewd);
          chk("mem_we", o_mwe, we);
          chk("mem_sel_io", o_io, eio);
          last_be = o_be;
          last_maddr = o_maddr;
          last_mwd = o_mwd;
          last_mwe = o_mwe;
          last_io = o_io;
          mem_ready = mvc == k;
          if (mvc == k) mem_rdata = rd & wm;
        end else mem_ready = 1'b0;
      end
    end
    chk("resp_seen", got, 1);
    chk("latency", lat, elat);
    chk("resp_err", last_err, eerr);
    chk("resp_rdata", last_rdata, erd);
    chk("mv_cycles", mvc, emv);
    last_lat = lat;
    last_mvc = mvc;
    @(negedge clk);
    chk("resp_pulse", o_rvalid, 0);
    chk("ready_again", o_ready, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got %0d exp %0d", 1, 0);
    $fatal(1, "simulation time limit");
  end
  initial begin
    logic [63:0] a;
    logic [1:0] sz;
    bit w64;
    repeat (3) @(negedge clk);
    chk("rst_ready32", a_ready, 0);
    chk("rst_ready64", b_ready, 0);
    rst = 1'b0;
    #1;
    chk("init_ready", a_ready, 1);
    chk("init_rvalid", a_rvalid, 0);
    chk("init_busy", a_busy, 0);
    chk("init_mv", a_mv, 0);
    chk("init_mwe", a_mwe, 0);
    chk("init_be", a_be, 0);
    chk("init_maddr", a_maddr, 0);
    chk("init_mwd", a_mwd, 0);
    chk("init_io", a_io, 0);
    chk("init_rdata", a_rdata, 0);
    chk("init_err", a_err, 0);
    chk("init_mv64", b_mv, 0);
    txn(0, 0, 2'd0, 0, 64'h1003, 64'h0, 64'h80FF_0000, 1);
    chk("t1_lb", last_rdata, 64'hFFFF_FF80);
    chk("t1_lat", last_lat, 2);
    txn(0, 0, 2'd0, 1, 64'h1003, 64'h0, 64'h80FF_0000, 1);
    chk("t1_lbu", last_rdata, 64'h80);
    txn(0, 1, 2'd1, 0, 64'h2002, 64'h1234_ABCD, 64'h0, 4);
    chk("t2_be", last_be, 8'b1100);
    chk("t2_addr", last_maddr, 64'h2000);
    chk("t2_wdata", last_mwd, 64'hABCD_ABCD);
    chk("t2_we", last_mwe, 1);
    chk("t2_lat", last_lat, 5);
    txn(0, 0, 2'd2, 0, 64'h6, 64'h0, 64'h0, 1);
    chk("t3_err", last_err, 1);
    chk("t3_mv", last_mvc, 0);
    txn(0, 0, 2'd3, 0, 64'h0, 64'h0, 64'h0, 1);
    chk("t3_size", last_err, 3);
    txn(0, 0, 2'd2, 0, 64'h40, 64'h0, 64'h5555, 99);
    chk("t4_tmo", last_err, 2);
    chk("t4_rdata", last_rdata, 0);
    chk("t4_mv", last_mvc, TO);
    txn(0, 0, 2'd2, 0, 64'h40, 64'h0, 64'h89AB_CDEF, TO);
    chk("t4_race", last_err, 0);
    chk("t4_race_rd", last_rdata, 64'h89AB_CDEF);
    txn(0, 0, 2'd2, 0, 64'hFFFF_FC60, 64'h0, 64'h1, 1);
    chk("t6_io", last_io, 1);
    txn(0, 0, 2'd2, 0, 64'h60, 64'h0, 64'h1, 1);
    chk("t6_noio", last_io, 0);
    txn(1, 0, 2'd3, 0, 64'h8, 64'h0, 64'h8000_0000_0000_0001, 1);
    chk("t6_be64", last_be, 8'hFF);
    chk("t6_ld64", last_rdata, 64'h8000_0000_0000_0001);
    @(negedge clk);
    w_sel = 1'b0;
    req_we = 1'b0;
    req_size = 2'd2;
    req_addr = 64'h100;
    mem_ready = 1'b0;
    rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    chk("t5_mv_pre", o_mv, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_mv", o_mv, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_rvalid", o_rvalid, 0);
    chk("t5_ready_rst", o_ready, 0);
    rst = 1'b0;
    #1;
    chk("t5_ready", o_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_resp", o_rvalid, 0);
    end
    for (int i = 0; i < 220; i++) begin
      w64 = i >= 160;
      sz = w64 ? 2'($urandom_range(0, 3)) : ($urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2)));
      a = {$urandom, $urandom};
      if (!w64) a[63:32] = '0;
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FC00 | 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a &= ~((64'd1 << sz) - 64'd1);
      txn(w64, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
          {$urandom, $urandom}, $urandom_range(1, TO + 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised multi-cycle load/store unit between the RISC-V core datapath and the memory/IO bridge. It replaces the core's single-cycle, always-ready data access path with a valid/ready handshake to a memory bus that may insert wait states. It performs byte-lane steering, sign/zero extension, misalignment and illegal-size detection, MMIO region decode, and a bus-timeout watchdog. The core stalls on `busy` until `resp_valid`.

## Interface
- `XLEN`, 32: data and address width; legal values are 32 and 64.
- `MMIO_BASE`, 32'hFFFF_FC00: base address of the IO region; zero-extended to XLEN.
- `MMIO_SIZE_LOG2`, 10: the IO region spans 2^MMIO_SIZE_LOG2 bytes.
- `TIMEOUT`, 255: maximum ACCESS cycles before abort; 0 disables the watchdog.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core request strobe.
- `req_ready` out 1: LSU accepts a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN=64).
- `req_unsigned` in 1: zero-extend loads (LBU/LHU/LWU).
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_err` out 2: 0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.
- `busy` out 1: high from accept through the RESP cycle.
- `mem_valid` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_be` out XLEN/8: byte enables.
- `mem_addr` out XLEN: address aligned to XLEN/8 bytes.
- `mem_wdata` out XLEN: lane-replicated store data.
- `mem_sel_io` out 1: address falls in the MMIO region.
- `mem_ready` in 1: bus completes the access.
- `mem_rdata` in XLEN: bus read data, valid when `mem_ready` is high.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- `req_ready` = (state == IDLE) && !rst.
- IDLE, request accepted (`req_valid && req_ready`):
  - Latch all request fields.
  - An illegal size, or an address not aligned to the access size, goes to RESP with err 3 or 1. No bus cycle is issued. Illegal size takes priority over misalignment.
  - Otherwise go to ACCESS.
- ACCESS:
  - `mem_valid` = 1.
  - All `mem_*` outputs come from registers and hold stable until `mem_ready` is sampled high.
  - `mem_ready` high: capture the extracted data, then go to RESP with err 0.
  - Watchdog: counter width is clog2(TIMEOUT+1). When the count reaches TIMEOUT (TIMEOUT ≠ 0) with no `mem_ready`, go to RESP with err 2 and `mem_valid` deasserted.
  - When `mem_ready` arrives in the same cycle as the timeout, `mem_ready` wins.
- RESP: `resp_valid` = 1 for exactly one cycle, then go to IDLE.
- Byte enables: byte = 1 << off; half = 2'b11 << off; word = 4'hF << off; double = all ones. Here off = `req_addr`[log2(XLEN/8)-1:0].
- Write data: the low byte, half or word of `req_wdata` is replicated across all lanes.
- Read extract: the selected lane is `mem_rdata` >> (off*8), truncated to the access size. It is sign-extended from the lane's own MSB unless `req_unsigned` is set. Stores return `resp_rdata` = 0.
- `mem_sel_io` = (`mem_addr` >> MMIO_SIZE_LOG2) == (MMIO_BASE >> MMIO_SIZE_LOG2).
- `mem_ready` outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; `resp_valid`, `resp_rdata`, `resp_err`, `busy`, all `mem_*` outputs and the watchdog counter = 0; `req_ready` = 0 while `rst` is high.
- Accept at edge E0: `mem_valid` is high after E0. `mem_ready` sampled at En gives `resp_valid` high for the cycle after En. `req_ready` is high again one cycle after the `resp_valid` cycle.
- Minimum latency, accept to `resp_valid`: 2 cycles with a zero-wait bus. An error without bus access takes 1 cycle.
- No back-to-back accepts: throughput is at most one access per 3 cycles.
- `rst` at any state: IDLE on the next edge; `mem_valid` low after that edge; no `resp_valid` for the aborted request.

## Structure
- Add to `riscv_defs.v`:
  - `LSU_SIZE_*` encodings.
  - `LSU_ERR_*` codes.
  - `LSU_ST_*` state encodings.
- Sub-module `riscv_lsu_align`: purely combinational. Computes byte enables, write replication, read extraction/extension and the alignment/size check. The parent holds the FSM, watchdog and registers.

## Test plan
1. LB at 0x1003 with `mem_rdata`=0x80FF_0000 and zero wait → `resp_rdata`=0xFFFF_FF80, err 0, `resp_valid` 2 cycles after accept. LBU at the same address → 0x0000_0080.
2. SH at 0x2002 with `req_wdata`=0x1234_ABCD → `mem_addr`=0x2000, `mem_be`=4'b1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1. `mem_ready` delayed 3 cycles → `mem_*` outputs stable throughout, `resp_valid` exactly 1 cycle after `mem_ready`.
3. LW at 0x0006 → `mem_valid` never asserts, `resp_valid` 1 cycle after accept, err 1. `req_size`=3 at XLEN=32 → err 3.
4. TIMEOUT=4 with `mem_ready` held low → `mem_valid` high for 4 cycles, then `resp_valid` with err 2 and `resp_rdata`=0. A repeat with `mem_ready` high on the 4th cycle → err 0.
5. `rst` pulsed during ACCESS → `mem_valid`=0 after that edge, no `resp_valid`, `req_ready`=1 the first cycle after `rst` is released.
6. LW at 0xFFFF_FC60 → `mem_sel_io`=1. LW at 0x0000_0060 → `mem_sel_io`=0. XLEN=64 LD at 0x8 → `mem_be`=8'hFF.
